// File: rtl/switch_vc_input_mux.sv
// Per-port round-robin VC selector that locks onto a VC for a whole packet.
// Define SWITCH_VC_REARB_EN for zero-bubble re-arbitration at packet end.
package switch_vc_pkg;
  typedef logic [31:0] flit_t;

  localparam logic [3:0] FMT_SHORT_READ  = 4'h0;
  localparam logic [3:0] FMT_SHORT_WRITE = 4'h1;
  localparam logic [3:0] FMT_LONG_READ   = 4'h2;
  localparam logic [3:0] FMT_LONG_WRITE  = 4'h3;
endpackage

module switch_vc_input_mux
  import switch_vc_pkg::*;
#(
  parameter int NUM_PORTS    = 5,
  parameter int NUM_VCS      = 2,
  parameter int LENGTH_WIDTH = 8,
  parameter int VC_W         = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic  [NUM_PORTS-1:0][NUM_VCS-1:0]  vc_valid,
  input  flit_t [NUM_PORTS-1:0][NUM_VCS-1:0]  vc_rdata,
  output logic  [NUM_PORTS-1:0][NUM_VCS-1:0]  vc_ren,
  input  logic  [NUM_PORTS-1:0]               pop,
  output logic  [NUM_PORTS-1:0]               out_valid,
  output flit_t [NUM_PORTS-1:0]               out_flit,
  output logic  [NUM_PORTS-1:0][VC_W-1:0]     out_vc,
  output logic  [NUM_PORTS-1:0]               pkt_start,
  output logic  [NUM_PORTS-1:0]               pkt_end
);
  typedef enum logic {IDLE, ACTIVE} state_t;

  // Returns {found, index} of the first requester at or after ptr, wrapping.
  function automatic logic [VC_W:0] rr_pick(input logic [NUM_VCS-1:0] req,
                                            input logic [VC_W-1:0]    ptr);
    logic [VC_W:0] res;
    int            idx;
    res = '0;
    for (int i = NUM_VCS - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_VCS) idx = idx - NUM_VCS;
      if (req[idx[VC_W-1:0]]) res = {1'b1, idx[VC_W-1:0]};
    end
    return res;
  endfunction

  function automatic logic [VC_W-1:0] vc_inc(input logic [VC_W-1:0] v);
    return (int'(v) == NUM_VCS - 1) ? '0 : v + VC_W'(1);
  endfunction

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    state_t                  state_q, state_d;
    logic [VC_W-1:0]         sel_q, sel_d, rr_ptr_q, rr_ptr_d;
    logic [LENGTH_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d;
    flit_t                   head;
    logic [LENGTH_WIDTH-1:0] total;
    logic                    active, head_valid, is_last, accept;
    logic [VC_W:0]           arb;
    logic [NUM_VCS-1:0]      ren;
`ifdef SWITCH_VC_REARB_EN
    logic [VC_W:0]           rearb;
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q  <= IDLE;
        sel_q    <= '0;
        rr_ptr_q <= '0;
        cnt_q    <= '0;
        len_q    <= '0;
      end else begin
        state_q  <= state_d;
        sel_q    <= sel_d;
        rr_ptr_q <= rr_ptr_d;
        cnt_q    <= cnt_d;
        len_q    <= len_d;
      end
    end

    always_comb begin
      head       = vc_rdata[gi][sel_q];
      active     = (state_q == ACTIVE);
      head_valid = active && vc_valid[gi][sel_q];
      // Length decode is only meaningful while the header is at the head.
      case (head[31:28])
        FMT_SHORT_READ, FMT_SHORT_WRITE:
          total = LENGTH_WIDTH'(head[3:0]) + LENGTH_WIDTH'(1);
        FMT_LONG_READ, FMT_LONG_WRITE:
          total = LENGTH_WIDTH'(head[6:0]) + LENGTH_WIDTH'(2);
        default:
          total = LENGTH_WIDTH'(head[6:0]) + LENGTH_WIDTH'(1);
      endcase
      is_last = head_valid && ((cnt_q == '0) ? (total == LENGTH_WIDTH'(1))
                                             : (cnt_q == len_q - LENGTH_WIDTH'(1)));
      accept  = head_valid && pop[gi];
      arb     = rr_pick(vc_valid[gi], rr_ptr_q);
`ifdef SWITCH_VC_REARB_EN
      rearb   = rr_pick(vc_valid[gi], vc_inc(sel_q));
`endif

      ren      = '0;
      state_d  = state_q;
      sel_d    = sel_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      if (accept) ren[sel_q] = 1'b1;

      case (state_q)
        IDLE: begin
          if (arb[VC_W]) begin
            state_d  = ACTIVE;
            sel_d    = arb[VC_W-1:0];
            rr_ptr_d = vc_inc(arb[VC_W-1:0]);
            cnt_d    = '0;
          end
        end
        ACTIVE: begin
          if (accept) begin
            if (cnt_q == '0) len_d = total;
            cnt_d = cnt_q + LENGTH_WIDTH'(1);
            if (is_last) begin
              cnt_d = '0;
`ifdef SWITCH_VC_REARB_EN
              // Just-finished VC is searched last so other VCs get a turn.
              if (rearb[VC_W]) begin
                sel_d    = rearb[VC_W-1:0];
                rr_ptr_d = vc_inc(rearb[VC_W-1:0]);
              end else begin
                state_d = IDLE;
              end
`else
              state_d = IDLE;
`endif
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    assign out_valid[gi] = head_valid;
    assign out_flit[gi]  = active ? head : '0;
    assign out_vc[gi]    = active ? sel_q : '0;
    assign pkt_start[gi] = head_valid && (cnt_q == '0);
    assign pkt_end[gi]   = is_last;
    assign vc_ren[gi]    = ren;
  end
endmodule

// File: tb/tb_switch_vc_input_mux.sv
// Bench for switch_vc_input_mux: queue-backed VC buffers, packet-level model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_switch_vc_input_mux;
  import switch_vc_pkg::*;

  localparam int NP = 5;
  localparam int NV = 2;
  localparam int VW = 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic  [NP-1:0][NV-1:0]  vc_valid;
  flit_t [NP-1:0][NV-1:0]  vc_rdata;
  logic  [NP-1:0][NV-1:0]  vc_ren;
  logic  [NP-1:0]          pop;
  logic  [NP-1:0]          out_valid;
  flit_t [NP-1:0]          out_flit;
  logic  [NP-1:0][VW-1:0]  out_vc;
  logic  [NP-1:0]          pkt_start;
  logic  [NP-1:0]          pkt_end;

  always #5 clk = ~clk;

  switch_vc_input_mux #(.NUM_PORTS(NP), .NUM_VCS(NV), .LENGTH_WIDTH(8), .VC_W(VW)) dut (
    .clk(clk), .rst(rst), .vc_valid(vc_valid), .vc_rdata(vc_rdata), .vc_ren(vc_ren),
    .pop(pop), .out_valid(out_valid), .out_flit(out_flit), .out_vc(out_vc),
    .pkt_start(pkt_start), .pkt_end(pkt_end)
  );

  int    n_checks = 0;
  int    n_fail   = 0;
  flit_t bufq [NP][NV][$];
  flit_t srcq [NP][NV][$];
  bit    hold [NP][NV];
  bit    vis  [NP][NV];
  bit    popv [NP];
  bit    exp_v[NP];
  int    pop_pct = 100;
  int    inj_pct = 100;
  // Model: packet lock per port, flits remaining (0 = header not yet taken).
  bit    m_locked[NP];
  int    m_cur[NP], m_rem[NP], m_rr[NP];
  int    tr_v[$], tr_s[$], tr_e[$], tr_vc[$], tr_acc[$], tr_ren[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_total(flit_t h);
    int f;
    f = int'(h[31:28]);
    if (f <= 1) return 1 + int'(h[3:0]);
    if (f <= 3) return 2 + int'(h[6:0]);
    return 1 + int'(h[6:0]);
  endfunction

  function automatic int pick(int p, int start);
    for (int k = 0; k < NV; k++) begin
      if (vis[p][(start + k) % NV]) return (start + k) % NV;
    end
    return -1;
  endfunction

  task automatic push_pkt(int p, int v, logic [3:0] fmt, logic [6:0] low, bit to_src);
    flit_t h;
    int    n;
    h = {fmt, 21'($urandom()), low};
    n = model_total(h);
    if (to_src) srcq[p][v].push_back(h); else bufq[p][v].push_back(h);
    for (int i = 1; i < n; i++) begin
      if (to_src) srcq[p][v].push_back($urandom()); else bufq[p][v].push_back($urandom());
    end
  endtask

  task automatic clear_trace();
    tr_v.delete(); tr_s.delete(); tr_e.delete(); tr_vc.delete(); tr_acc.delete(); tr_ren.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int p = 0; p < NP; p++) begin
      for (int v = 0; v < NV; v++) begin
        bufq[p][v].delete(); srcq[p][v].delete(); hold[p][v] = 1'b0;
      end
      m_locked[p] = 1'b0; m_cur[p] = 0; m_rem[p] = 0; m_rr[p] = 0;
    end
    vc_valid = '0; vc_rdata = '0; pop = '0;
    @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset pkt_start", pkt_start, 0);
    chk("reset pkt_end", pkt_end, 0);
    chk("reset out_vc", out_vc, 0);
    chk("reset vc_ren", vc_ren, 0);
    chk("reset out_flit", out_flit, 0);
    rst = 1'b0;
    clear_trace();
  endtask

  task automatic step();
    bit           e_s, e_e;
    int           e_vc, w;
    flit_t        e_f, h;
    logic [NV-1:0] e_ren;
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      for (int v = 0; v < NV; v++) begin
        vis[p][v]      = (bufq[p][v].size() > 0) && !hold[p][v];
        vc_valid[p][v] = vis[p][v];
        vc_rdata[p][v] = (bufq[p][v].size() > 0) ? bufq[p][v][0] : flit_t'($urandom());
      end
      popv[p] = ($urandom_range(0, 99) < pop_pct);
      pop[p]  = popv[p];
    end
    #1;
    for (int p = 0; p < NP; p++) begin
      exp_v[p] = 1'b0; e_s = 1'b0; e_e = 1'b0; e_vc = 0; e_f = '0; e_ren = '0;
      if (m_locked[p]) begin
        e_vc = m_cur[p];
        if (vis[p][m_cur[p]]) begin
          e_f      = bufq[p][m_cur[p]][0];
          exp_v[p] = 1'b1;
          e_s      = (m_rem[p] == 0);
          e_e      = e_s ? (model_total(e_f) == 1) : (m_rem[p] == 1);
          if (popv[p]) e_ren[m_cur[p]] = 1'b1;
        end
      end
      chk($sformatf("p%0d out_valid", p), out_valid[p], exp_v[p]);
      chk($sformatf("p%0d pkt_start", p), pkt_start[p], e_s);
      chk($sformatf("p%0d pkt_end", p), pkt_end[p], e_e);
      chk($sformatf("p%0d out_vc", p), out_vc[p], e_vc);
      chk($sformatf("p%0d vc_ren", p), vc_ren[p], e_ren);
      if (exp_v[p]) chk($sformatf("p%0d out_flit", p), out_flit[p], e_f);
    end
    tr_v.push_back(int'(out_valid[0]));
    tr_s.push_back(int'(pkt_start[0]));
    tr_e.push_back(int'(pkt_end[0]));
    tr_vc.push_back(int'(out_vc[0]));
    tr_acc.push_back(int'(out_valid[0] && pop[0]));
    tr_ren.push_back(int'(vc_ren[0]));
    @(posedge clk);
    for (int p = 0; p < NP; p++) begin
      if (!m_locked[p]) begin
        w = pick(p, m_rr[p]);
        if (w >= 0) begin
          m_locked[p] = 1'b1; m_cur[p] = w; m_rr[p] = (w + 1) % NV; m_rem[p] = 0;
        end
      end else if (exp_v[p] && popv[p]) begin
        h = bufq[p][m_cur[p]].pop_front();
        if (m_rem[p] == 0) m_rem[p] = model_total(h);
        m_rem[p]--;
        if (m_rem[p] == 0) begin
          m_locked[p] = 1'b0;
`ifdef SWITCH_VC_REARB_EN
          w = pick(p, (m_cur[p] + 1) % NV);
          if (w >= 0) begin
            m_locked[p] = 1'b1; m_cur[p] = w; m_rr[p] = (w + 1) % NV;
          end
`endif
        end
      end
      for (int v = 0; v < NV; v++) begin
        if (srcq[p][v].size() > 0 && $urandom_range(0, 99) < inj_pct)
          bufq[p][v].push_back(srcq[p][v].pop_front());
      end
    end
  endtask

  function automatic int tr_sum(int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  int lens[$], starts[$], tstart[$], tend[$];

  task automatic scan_trace();
    int cur = 0;
    lens.delete(); starts.delete(); tstart.delete(); tend.delete();
    foreach (tr_v[i]) begin
      if (tr_s[i] != 0 && tr_acc[i] != 0) begin starts.push_back(tr_vc[i]); tstart.push_back(i); end
      cur += tr_acc[i];
      if (tr_e[i] != 0 && tr_acc[i] != 0) begin lens.push_back(cur); tend.push_back(i); cur = 0; end
    end
  endtask

  initial begin
    rst = 1'b1; vc_valid = '0; vc_rdata = '0; pop = '0;

    // Short write, 4 flits on VC1
    do_reset(); pop_pct = 100;
    push_pkt(0, 1, 4'h1, 7'h03, 1'b0);
    repeat (7) step();
    chk("A idle cycle", tr_v[0], 0);
    chk("A first valid", tr_v[1], 1);
    chk("A out_vc", tr_vc[1], 1);
    chk("A pkt_start", tr_s[1], 1);
    chk("A flit count", tr_sum(tr_acc), 4);
    chk("A pkt_end flit3", tr_e[4], 1);
    chk("A idle after", tr_v[5], 0);

    // Long read lengths 2 and 129
    do_reset();
    push_pkt(0, 0, 4'h2, 7'h00, 1'b0);
    push_pkt(0, 0, 4'h2, 7'h7f, 1'b0);
    repeat (140) step();
    scan_trace();
    chk("B packets", lens.size(), 2);
    chk("B len0", (lens.size() > 0) ? lens[0] : -1, 2);
    chk("B len1", (lens.size() > 1) ? lens[1] : -1, 129);

    // Single-flit short packet
    do_reset();
    push_pkt(0, 0, 4'h0, 7'h70, 1'b0);
    repeat (3) step();
    chk("C start", tr_s[1], 1);
    chk("C end", tr_e[1], 1);
    chk("C idle after", tr_v[2], 0);

    // Alternation and packet gap
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push_pkt(0, 0, 4'h0, 7'h01, 1'b0);
      push_pkt(0, 1, 4'h0, 7'h01, 1'b0);
    end
    repeat (20) step();
    scan_trace();
    for (int k = 0; k < 4; k++)
      chk($sformatf("D grant%0d", k), (starts.size() > k) ? starts[k] : -1, k % 2);
`ifdef SWITCH_VC_REARB_EN
    chk("D gap", (tstart.size() > 1 && tend.size() > 0) ? tstart[1] - tend[0] : -1, 1);
`else
    chk("D gap", (tstart.size() > 1 && tend.size() > 0) ? tstart[1] - tend[0] : -1, 2);
`endif

    // Mid-packet stall of the locked VC while the other VC waits
    do_reset();
    push_pkt(0, 0, 4'h1, 7'h03, 1'b0);
    push_pkt(0, 1, 4'h1, 7'h01, 1'b0);
    repeat (3) step();
    hold[0][0] = 1'b1;
    repeat (3) step();
    hold[0][0] = 1'b0;
    repeat (10) step();
    for (int t = 3; t < 6; t++) begin
      chk($sformatf("E stall valid t%0d", t), tr_v[t], 0);
      chk($sformatf("E stall vc t%0d", t), tr_vc[t], 0);
      chk($sformatf("E stall ren t%0d", t), tr_ren[t], 0);
    end
    chk("E resume valid", tr_v[6], 1);
    chk("E resume not header", tr_s[6], 0);
    chk("E end", tr_e[7], 1);
    scan_trace();
    chk("E next grant", (starts.size() > 1) ? starts[1] : -1, 1);

    // Asynchronous reset in the middle of a 5-flit packet
    do_reset();
    push_pkt(0, 0, 4'h1, 7'h04, 1'b0);
    repeat (3) step();
    #1;
    chk("F mid-packet valid", out_valid[0], 1);
    #1 rst = 1'b1;
    #1;
    chk("F async out_valid", out_valid, 0);
    chk("F async vc_ren", vc_ren, 0);
    chk("F async pkt_start", pkt_start, 0);
    do_reset();
    push_pkt(0, 1, 4'h1, 7'h01, 1'b0);
    repeat (4) step();
    chk("F restart idle", tr_v[0], 0);
    chk("F restart start", tr_s[1], 1);
    chk("F restart vc", tr_vc[1], 1);
    chk("F restart end", tr_e[2], 1);

    // Randomized traffic on all ports
    do_reset();
    inj_pct = 60;
    for (int chunk = 0; chunk < 4; chunk++) begin
      case (chunk)
        0: pop_pct = 100;
        1: pop_pct = 70;
        2: pop_pct = 30;
        default: pop_pct = 90;
      endcase
      repeat (1000) begin
        for (int p = 0; p < NP; p++) begin
          for (int v = 0; v < NV; v++) begin
            if (srcq[p][v].size() == 0 && $urandom_range(0, 99) < 15)
              push_pkt(p, v, 4'($urandom()),
                       ($urandom_range(0, 19) == 0) ? 7'($urandom()) : 7'($urandom_range(0, 6)),
                       1'b1);
          end
        end
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/switch_vc_input_mux.md
# switch_vc_input_mux

Per-input-port, packet-aware virtual-channel selector for the next-generation switch. Sits between the per-VC input buffers and the crossbar/switch allocator. For each of NUM_PORTS inputs it picks one of NUM_VCS non-empty VC buffers round-robin, locks onto it for a whole packet by decoding the header length field, and releases the lock only at the packet's last flit. This replaces the fixed two-buffer (normal/VC) toggle with N-way VC selection and wormhole-safe packet locking.

## Interface
- NUM_PORTS, 5, number of input ports (independent mux instances).
- NUM_VCS, 2, VC buffers per port (≥2); VC index width VC_W = $clog2(NUM_VCS).
- LENGTH_WIDTH, 8, flit-count width; must hold 129.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- vc_valid  in  [NUM_PORTS][NUM_VCS]  buffer non-empty.
- vc_rdata  in  flit_t [NUM_PORTS][NUM_VCS]  head flit of each VC buffer.
- vc_ren  out  [NUM_PORTS][NUM_VCS]  pop strobe to buffer; one-hot or zero per port.
- pop  in  [NUM_PORTS]  switch-allocator grant; consumes out_flit this cycle.
- out_valid  out  [NUM_PORTS]  out_flit valid.
- out_flit  out  flit_t [NUM_PORTS]  selected head flit.
- out_vc  out  [NUM_PORTS][VC_W]  locked VC.
- pkt_start  out  [NUM_PORTS]  out_flit is a header.
- pkt_end  out  [NUM_PORTS]  out_flit is last flit of packet.

## Operation
- Per-port FSM: IDLE, ACTIVE. Registers: sel[VC_W], rr_ptr[VC_W], cnt, len (LENGTH_WIDTH each).
- IDLE: out_valid=0, vc_ren=0. If any vc_valid: winner = first valid VC searching from rr_ptr upward with wrap; sel<=winner, rr_ptr<=winner+1 (mod NUM_VCS), cnt<=0, -> ACTIVE.
- ACTIVE: out_flit=vc_rdata[sel], out_vc=sel, out_valid=vc_valid[sel], pkt_start=out_valid&&(cnt==0). vc_ren[sel]=pop&&out_valid; pop while !out_valid ignored.
- Header decode (cnt==0, combinational from payload[31:28]): FMT_SHORT_READ/FMT_SHORT_WRITE -> total=1+payload[3:0]; FMT_LONG_READ/FMT_LONG_WRITE -> total=2+payload[6:0]; other -> total=1+payload[6:0]. len<=total on header pop.
- pkt_end = out_valid && (cnt==0 ? total==1 : cnt==len-1).
- Each accepted pop: cnt<=cnt+1; if pkt_end -> IDLE (cnt<=0).
- No interleaving: vc_valid[sel] low mid-packet holds lock, out_valid=0; other VCs wait even if valid.
- Only vc_rdata[sel] is observed; payload of unselected VCs is don't-care.

## Timing
- Reset: state=IDLE, sel=0, rr_ptr=0, cnt=0, len=0; all outputs 0. Reset mid-packet abandons lock immediately (async); no flush of buffers.
- Arbitration latency: 1 cycle from vc_valid to out_valid (IDLE cycle).
- Throughput in ACTIVE: one flit per cycle while vc_valid[sel]&&pop.
- Packet gap: one IDLE bubble between packets on the same port (see Configuration).
- cnt never exceeds len-1; max packet 129 flits.
- Ports fully independent; no cross-port state.

## Configuration
- SWITCH_VC_REARB_EN defined: on a pop with pkt_end, the port re-arbitrates the same cycle using vc_valid excluding the just-popped VC's current head if it is empty after pop (use vc_valid as sampled, treat sel as lower priority via rr_ptr=sel+1); if a winner exists, stay ACTIVE with new sel, cnt=0 — zero-bubble back-to-back packets. No winner -> IDLE.
- Not defined: always IDLE for one cycle after pkt_end (baseline above).

## Test plan
- Reset then VC1 valid with FMT_SHORT_WRITE header, payload[3:0]=3, pop held high -> out_valid after 1 cycle, out_vc=1, 4 flits, pkt_start on flit 0, pkt_end on flit 3, then IDLE.
- FMT_LONG_READ, payload[6:0]=0 on VC0 -> exactly 2 flits; payload[6:0]=127 -> 129 flits, cnt no overflow.
- Short header with payload[3:0]=0 -> single flit with pkt_start and pkt_end both high.
- VC0 and VC1 both valid continuously, 2-flit packets -> grants alternate 0,1,0,1; bubble of 1 cycle between packets without SWITCH_VC_REARB_EN, none with it.
- Mid-packet vc_valid[sel] low 3 cycles while other VC valid -> out_valid=0, out_vc unchanged, no vc_ren to other VC, packet resumes.
- Assert rst at flit 2 of 5 -> outputs 0 asynchronously; after release, new header starts cleanly with cnt=0.
